// File: rtl/uart_rx_fsm.sv
// UART receive sequencing controller: tracks frame phase from the external edge/bit counter,
// strobes the sampler, deserializer and checkers, and reports one result per completed frame.
module uart_rx_fsm #(
  parameter int unsigned PRESCALE  = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CHK_EDGE  = PRESCALE / 2 + 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [4:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);

  localparam logic [4:0] ChkEdge  = 5'(CHK_EDGE);
  localparam logic [4:0] LastEdge = 5'(PRESCALE - 1);
  localparam logic [3:0] LastData = 4'(DATA_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_flag_q, par_flag_d;
  logic   data_valid_q, data_valid_d;
  logic   parity_err_q, parity_err_d;
  logic   framing_err_q, framing_err_d;

  logic at_chk, at_last;

  assign at_chk  = (edge_cnt == ChkEdge);
  assign at_last = (edge_cnt == LastEdge);

  always_comb begin
    state_d       = state_q;
    par_en_d      = par_en_q;
    par_flag_d    = par_flag_q;
    data_valid_d  = 1'b0;
    parity_err_d  = 1'b0;
    framing_err_d = 1'b0;
    cnt_clr       = 1'b0;
    deser_en      = 1'b0;
    strt_chk_en   = 1'b0;
    par_chk_en    = 1'b0;
    stp_chk_en    = 1'b0;

    case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d    = StStart;
          par_en_d   = PAR_EN;
          par_flag_d = 1'b0;
        end
      end

      StStart: begin
        if (at_chk) begin
          strt_chk_en = 1'b1;
          // A start bit that samples high was noise: drop back and rearm the counter.
          if (strt_glitch) begin
            cnt_clr = 1'b1;
            state_d = StIdle;
          end
        end else if (at_last) begin
          state_d = StData;
        end
      end

      StData: begin
        if (at_chk) begin
          deser_en = 1'b1;
        end
        if (at_last && (bit_cnt == LastData)) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end

      StParity: begin
        if (at_chk) begin
          par_chk_en = 1'b1;
          par_flag_d = par_err;
        end
        if (at_last) begin
          state_d = StStop;
        end
      end

      StStop: begin
        // Leave at mid-stop-bit so a start edge right after the stop bit is not missed.
        if (at_chk) begin
          stp_chk_en    = 1'b1;
          cnt_clr       = 1'b1;
          state_d       = StIdle;
          par_flag_d    = 1'b0;
          framing_err_d = stp_err;
          parity_err_d  = !stp_err && par_flag_q;
          data_valid_d  = !stp_err && !par_flag_q;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign cnt_en  = busy;
  assign samp_en = busy;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      par_en_q      <= 1'b0;
      par_flag_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      par_en_q      <= par_en_d;
      par_flag_q    <= par_flag_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: models the edge/bit counter and checks every output per cycle
// against hand-derived frame timing (PRESCALE=8, DATA_BITS=8, check edge 6).
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch = 1'b1;
  logic       par_err = 1'b1;
  logic       stp_err = 1'b1;
  logic       cnt_en, cnt_clr, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, parity_err, framing_err, busy;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fsm #(
    .PRESCALE (8),
    .DATA_BITS(8)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .strt_glitch(strt_glitch),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .samp_en    (samp_en),
    .deser_en   (deser_en),
    .strt_chk_en(strt_chk_en),
    .par_chk_en (par_chk_en),
    .stp_chk_en (stp_chk_en),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .framing_err(framing_err),
    .busy       (busy)
  );

  // External edge/bit counter as seen by the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (cnt_clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (cnt_en) begin
      if (edge_cnt == 5'd7) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end
    end
  end

  assign obs = {cnt_en, cnt_clr, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                data_valid, parity_err, framing_err, busy};

  function automatic logic [10:0] mk(input bit bsy, input bit clr, input bit des, input bit strt,
                                     input bit parc, input bit stpc, input bit dv, input bit pe,
                                     input bit fe);
    return {bsy, clr, bsy, des, strt, parc, stpc, dv, pe, fe, bsy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [10:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_bad++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, want);
    end
  endtask

  // One IDLE cycle, then RX_IN falls; the following edge is t0.
  task automatic start_edge(input bit p);
    step();
    rx_in       = 1'b0;
    par_en      = p;
    strt_glitch = 1'b1;
    par_err     = 1'b1;
    stp_err     = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input bit p, input bit glitch,
                           input bit perr, input bit serr, input bit b2b, input int kstop);
    int  s, k_end, kmax, b;
    bit  bsy, des, dv, pe, fe;
    logic [7:0] d;
    d     = data;
    s     = 9 + int'(p);
    k_end = glitch ? 6 : s * 8 + 6;
    kmax  = b2b ? k_end + 1 : k_end + 3;
    if (kstop < kmax) kmax = kstop;
    for (int k = 0; k <= kmax; k++) begin
      step();
      b = k / 8;
      if (glitch) rx_in = 1'b1;
      else if (k > k_end) rx_in = (b2b && k == k_end + 1) ? 1'b0 : 1'b1;
      else if (b == 0) rx_in = 1'b0;
      else if (b <= 8) rx_in = d[b-1];
      else if (p && b == 9) rx_in = ^d;
      else rx_in = 1'b1;
      // Flip PAR_EN mid-frame; only the value latched at the start edge may count.
      par_en      = (k >= 1 && k <= k_end) ? !p : p;
      // Checker inputs carry the opposite value whenever their strobe is not due.
      strt_glitch = (k == 6) ? glitch : !glitch;
      par_err     = (k == 78) ? perr : !perr;
      stp_err     = (k == k_end) ? serr : !serr;
      #1;
      bsy = (k <= k_end);
      des = !glitch && bsy && (k % 8 == 6) && b >= 1 && b <= 8;
      dv  = !glitch && (k == k_end + 1) && !serr && !(p && perr);
      pe  = !glitch && (k == k_end + 1) && !serr && p && perr;
      fe  = !glitch && (k == k_end + 1) && serr;
      chk(tag, k, mk(bsy, k == k_end, des, k == 6, p && !glitch && k == 78,
                     !glitch && k == k_end, dv, pe, fe));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", -1, '0);
    #2 rst_n = 1'b1;
    step();
    chk("idle_rx_high", -1, '0);

    start_edge(1'b0);
    run_frame("t1_a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 999);

    start_edge(1'b1);
    run_frame("t2_3c_par", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 999);

    start_edge(1'b0);
    run_frame("t3_glitch", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 999);

    start_edge(1'b1);
    run_frame("t4_par_err", 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 999);
    start_edge(1'b1);
    run_frame("t4_frm_over_par", 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 999);
    start_edge(1'b0);
    run_frame("t4_frm_nopar", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 999);

    start_edge(1'b0);
    run_frame("t5_b2b_first", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 999);
    run_frame("t5_b2b_second", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 999);

    start_edge(1'b0);
    run_frame("t6_pre_reset", 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40);
    rx_in = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", 40, '0);
    step();
    chk("t6_held_reset", 41, '0);
    #2 rst_n = 1'b1;
    step();
    chk("t6_idle_after", 42, '0);
    start_edge(1'b0);
    run_frame("t6_post_reset", 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
